// File: rtl/env_adsr_sequencer_pkg.sv
// env_adsr_sequencer_pkg: shared widths, limits and envelope state encoding
package env_adsr_sequencer_pkg;
  localparam int OP_NUM_WIDTH = 5;
  localparam int NUM_OPERATORS_PER_BANK = 18;
  localparam int REG_ENV_WIDTH = 4;
  localparam int ENV_RATE_COUNTER_OVERFLOW_WIDTH = 3;
  localparam int ENV_WIDTH = 9;
  localparam logic [ENV_WIDTH-1:0] ENV_SILENT = 9'd511;
  typedef enum logic [1:0] {ATTACK, DECAY, SUSTAIN, RELEASE} env_state_t;
endpackage

// File: rtl/env_adsr_sequencer_env_step.sv
// env_adsr_sequencer_env_step: combinational next env/state for one operator step
module env_adsr_sequencer_env_step
  import env_adsr_sequencer_pkg::*;
(
  input  env_state_t                                     state_i,
  input  logic [ENV_WIDTH-1:0]                           env_i,
  input  logic [ENV_RATE_COUNTER_OVERFLOW_WIDTH-1:0]     ovf_i,
  input  logic [3:0]                                     sl_i,
  input  logic                                           etr_i,
  output logic [ENV_WIDTH-1:0]                           env_o,
  output env_state_t                                     state_o
);
  logic [11:0] w_env, w_ovf, prod, dec_raw, dec, att, sum, tgt, dcy, sat, env_n;
  // 12-bit intermediates keep every step clear of wrap at 0 and 511
  always_comb begin
    w_env = {3'b0, env_i};
    w_ovf = {9'b0, ovf_i};
    prod = w_env * w_ovf;
    dec_raw = prod >> 3;
    dec = (ovf_i != '0 && dec_raw == '0) ? 12'd1 : dec_raw;
    att = (dec >= w_env) ? 12'd0 : w_env - dec;
    sum = w_env + w_ovf;
    tgt = (sl_i == 4'd15) ? 12'd496 : {4'b0, sl_i, 4'b0};
    dcy = (sum >= tgt) ? tgt : sum;
    sat = (sum >= 12'd511) ? 12'd511 : sum;
    env_n = w_env;
    state_o = state_i;
    if (ovf_i != '0) begin
      unique case (state_i)
        ATTACK: begin
          env_n = att;
          state_o = (att == '0) ? DECAY : ATTACK;
        end
        DECAY: begin
          env_n = dcy;
          state_o = (dcy == tgt) ? SUSTAIN : DECAY;
        end
        SUSTAIN: env_n = etr_i ? w_env : sat;
        default: env_n = sat;
      endcase
    end
    env_o = (env_n > 12'd511) ? ENV_SILENT : env_n[ENV_WIDTH-1:0];
  end
endmodule

// File: rtl/env_adsr_sequencer.sv
// env_adsr_sequencer: per-operator ADSR envelope state machine time-multiplexed over one bank
module env_adsr_sequencer
  import env_adsr_sequencer_pkg::*;
(
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           sample_clk_en,
  input  logic [OP_NUM_WIDTH-1:0]                        op_num,
  input  logic                                           key_on,
  input  logic [REG_ENV_WIDTH-1:0]                       ar,
  input  logic [REG_ENV_WIDTH-1:0]                       dr,
  input  logic [REG_ENV_WIDTH-1:0]                       rr,
  input  logic [3:0]                                     sl,
  input  logic                                           etr,
  input  logic [ENV_RATE_COUNTER_OVERFLOW_WIDTH-1:0]     rate_counter_overflow,
  output logic [REG_ENV_WIDTH-1:0]                       requested_rate,
  output logic [ENV_WIDTH-1:0]                           env_out
);
  env_state_t                        state_q [NUM_OPERATORS_PER_BANK];
  logic [ENV_WIDTH-1:0]              env_q   [NUM_OPERATORS_PER_BANK];
  logic [NUM_OPERATORS_PER_BANK-1:0] kon_q;
  logic                              upd_q;
  logic [ENV_WIDTH-1:0]              env_out_q;
  env_state_t                        cur_state, step_state, state_d;
  logic [ENV_WIDTH-1:0]              cur_env, step_env, env_d;
  logic                              rise, fall, inst_attack;

  assign cur_state = state_q[op_num];
  assign cur_env = env_q[op_num];
  assign env_out = env_out_q;

  env_adsr_sequencer_env_step u_env_step (
    .state_i (cur_state),
    .env_i   (cur_env),
    .ovf_i   (rate_counter_overflow),
    .sl_i    (sl),
    .etr_i   (etr),
    .env_o   (step_env),
    .state_o (step_state)
  );

  // key edges override the rate step; ar=15 skips attack entirely
  always_comb begin
    rise = key_on & ~kon_q[op_num];
    fall = ~key_on & kon_q[op_num];
    inst_attack = rise && ar == 4'd15;
    env_d = inst_attack ? '0 : (rise || fall) ? cur_env : step_env;
    state_d = rise ? (inst_attack ? DECAY : ATTACK) : fall ? RELEASE : step_state;
    requested_rate = (cur_state == ATTACK) ? ar :
                     (cur_state == DECAY) ? dr :
                     (cur_state == SUSTAIN) ? (etr ? '0 : rr) : rr;
  end

  // operator state update on the cycle after sample_clk_en
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OPERATORS_PER_BANK; i++) begin
        state_q[i] <= RELEASE;
        env_q[i] <= ENV_SILENT;
      end
      kon_q <= '0;
      upd_q <= 1'b0;
      env_out_q <= ENV_SILENT;
    end else begin
      upd_q <= sample_clk_en;
      if (upd_q) begin
        state_q[op_num] <= state_d;
        env_q[op_num] <= env_d;
        kon_q[op_num] <= key_on;
        env_out_q <= env_d;
      end
    end
  end
endmodule

// File: tb/tb_env_adsr_sequencer.sv
// tb_env_adsr_sequencer: directed and randomized checks against an arithmetic envelope model
module tb_env_adsr_sequencer;
  localparam int NOPS = 18;
  localparam int SA = 0, SD = 1, SS = 2, SR = 3;

  logic       clk = 0, rst_n = 0, sample_clk_en = 0, key_on = 0, etr = 0;
  logic [4:0] op_num = 0;
  logic [3:0] ar = 0, dr = 0, rr = 0, sl = 0, requested_rate;
  logic [2:0] rate_counter_overflow = 0;
  logic [8:0] env_out;

  int m_env [NOPS];
  int m_st  [NOPS];
  bit m_kon [NOPS];
  int tests = 0, failed = 0;

  env_adsr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sample_clk_en(sample_clk_en), .op_num(op_num),
    .key_on(key_on), .ar(ar), .dr(dr), .rr(rr), .sl(sl), .etr(etr),
    .rate_counter_overflow(rate_counter_overflow),
    .requested_rate(requested_rate), .env_out(env_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_rate(input int op);
    case (m_st[op])
      SA: return int'(ar);
      SD: return int'(dr);
      SS: return etr ? 0 : int'(rr);
      default: return int'(rr);
    endcase
  endfunction

  function automatic int min2(input int a, input int b);
    return a < b ? a : b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NOPS; i++) begin
      m_env[i] = 511;
      m_st[i] = SR;
      m_kon[i] = 0;
    end
  endtask

  task automatic model_step(input int op, input bit k, input int ovf);
    bit rise, fall;
    int dec, tgt;
    rise = k && !m_kon[op];
    fall = !k && m_kon[op];
    m_kon[op] = k;
    if (rise) begin
      if (ar == 15) begin
        m_env[op] = 0;
        m_st[op] = SD;
      end else m_st[op] = SA;
    end else if (fall) m_st[op] = SR;
    else if (ovf != 0) begin
      case (m_st[op])
        SA: begin
          dec = (m_env[op] * ovf) / 8;
          if (dec == 0) dec = 1;
          m_env[op] = m_env[op] > dec ? m_env[op] - dec : 0;
          if (m_env[op] == 0) m_st[op] = SD;
        end
        SD: begin
          tgt = (sl == 15) ? 496 : int'(sl) * 16;
          m_env[op] = min2(m_env[op] + ovf, tgt);
          if (m_env[op] == tgt) m_st[op] = SS;
        end
        SS: if (!etr) m_env[op] = min2(m_env[op] + ovf, 511);
        default: m_env[op] = min2(m_env[op] + ovf, 511);
      endcase
    end
  endtask

  task automatic upd(input string tag, input int op, input bit k, input int ovf);
    @(negedge clk);
    op_num = 5'(op);
    key_on = k;
    rate_counter_overflow = 3'(ovf);
    sample_clk_en = 1;
    @(negedge clk);
    sample_clk_en = 0;
    @(negedge clk);
    model_step(op, k, ovf);
    chk({tag, "_env"}, 32'(env_out), 32'(m_env[op]));
    chk({tag, "_rate"}, 32'(requested_rate), 32'(exp_rate(op)));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 0;
    sample_clk_en = 0;
    @(negedge clk);
    rst_n = 1;
    op_num = 0;
    model_reset();
    #1;
    chk({tag, "_env"}, 32'(env_out), 32'd511);
    chk({tag, "_rate"}, 32'(requested_rate), 32'(rr));
  endtask

  initial begin
    model_reset();
    ar = 8; dr = 5; rr = 9; sl = 2; etr = 1;
    repeat (2) @(posedge clk);
    do_reset("reset");
    upd("atk_rise", 0, 1, 4);
    chk("atk_rise_hold", 32'(env_out), 32'd511);
    for (int i = 0; i < 10; i++) upd("atk_step", 0, 1, 4);
    chk("atk_done_env", 32'(env_out), 32'd0);
    chk("atk_done_rate", 32'(requested_rate), 32'(dr));
    for (int i = 0; i < 32; i++) upd("dcy_step", 0, 1, 1);
    chk("dcy_done_env", 32'(env_out), 32'd32);
    for (int i = 0; i < 3; i++) upd("sus_hold", 0, 1, 7);
    chk("sus_hold_rate", 32'(requested_rate), 32'd0);
    ar = 15;
    upd("inst_atk", 1, 1, 3);
    chk("inst_atk_env", 32'(env_out), 32'd0);
    upd("inst_prep", 2, 1, 7);
    sl = 15;
    for (int i = 0; i < 71; i++) upd("dcy15", 2, 1, 7);
    chk("dcy15_env", 32'(env_out), 32'd496);
    etr = 0;
    upd("sus_rise", 2, 1, 7);
    upd("sus_rise", 2, 1, 5);
    chk("sus_508", 32'(env_out), 32'd508);
    upd("rel_fall", 2, 0, 7);
    chk("rel_fall_env", 32'(env_out), 32'd508);
    upd("rel_step", 2, 0, 7);
    chk("rel_sat", 32'(env_out), 32'd511);
    upd("rel_step", 2, 0, 7);
    ar = 6; sl = 4; etr = 1;
    for (int i = 0; i < 20; i++) begin
      upd("ilv0", 0, (i % 7) < 5, int'($urandom_range(0, 7)));
      upd("ilv17", 17, i < 10 || i > 14, int'($urandom_range(0, 7)));
    end
    upd("pre_rst", 5, 1, 0);
    upd("mid_atk", 5, 1, 2);
    do_reset("mid_reset");
    upd("post_rst0", 0, 0, 0);
    upd("post_rst17", 17, 0, 3);
    upd("post_rst_rise", 0, 1, 5);
    chk("post_rst_rise_rate", 32'(requested_rate), 32'(ar));
    for (int i = 0; i < 400; i++) begin
      ar = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      dr = 4'($urandom);
      rr = 4'($urandom);
      sl = 4'($urandom);
      etr = 1'($urandom);
      if ($urandom_range(0, 150) == 0) do_reset("rnd_reset");
      else begin
        int op;
        op = int'($urandom_range(0, 3)) * 5 + int'($urandom_range(0, 2));
        if (op >= NOPS) op = NOPS - 1;
        upd("rnd", op, $urandom_range(0, 9) < 7, int'($urandom_range(0, 7)));
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
